// File: rtl/alu_share_arbiter.sv
// ============================================================================
// alu_share_arbiter : round-robin sharing of one combinational ALU among NREQ
//                     requesters with registered operands and result.
// Revision 1.0
// ============================================================================
`default_nettype none

module alu_share_arbiter #(
   parameter  int NREQ  = 4,
   parameter  int WIDTH = 4,
   localparam int IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   input  logic [NREQ*3-1:0]     req_sel,
   output logic [NREQ-1:0]       req_ready,
   output logic [WIDTH-1:0]      alu_a,
   output logic [WIDTH-1:0]      alu_b,
   output logic [2:0]            alu_sel,
   input  logic [WIDTH-1:0]      alu_y,
   output logic                  rsp_valid,
   output logic [IDW-1:0]        rsp_id,
   output logic [WIDTH-1:0]      rsp_y,
   output logic                  rsp_err,
   input  logic                  rsp_ready
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [IDW-1:0]   rr_ptr;
   logic [IDW-1:0]   id_reg;
   logic [IDW-1:0]   win;
   logic [IDW-1:0]   ptr_next;
   logic [IDW:0]     cand;
   logic             found;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] y_reg;
   logic [2:0]       sel_reg;
   logic             err_reg;

   // Scan downward so the last hit is the nearest valid at or above rr_ptr.
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int k = NREQ-1; k >= 0; k--) begin
         cand = {1'b0, rr_ptr} + (IDW+1)'(k);
         if (cand >= (IDW+1)'(NREQ))
            cand = cand - (IDW+1)'(NREQ);
         if (req_valid[cand[IDW-1:0]]) begin
            found = 1'b1;
            win   = cand[IDW-1:0];
         end
      end
   end

   always_comb begin
      if (id_reg == IDW'(NREQ-1))
         ptr_next = '0;
      else
         ptr_next = id_reg + 1'b1;
   end

   // Grant is masked while reset is asserted so no requester sees a lost accept.
   always_comb begin
      state_next = state;
      req_ready  = '0;
      case (state)
         IDLE: begin
            if (found) begin
               state_next     = EXEC;
               req_ready[win] = rst_n;
            end
         end
         EXEC:    state_next = RESP;
         RESP:    if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         rr_ptr  <= '0;
         id_reg  <= '0;
         a_reg   <= '0;
         b_reg   <= '0;
         sel_reg <= '0;
         y_reg   <= '0;
         err_reg <= 1'b0;
      end else begin
         state <= state_next;
         if (state == IDLE && found) begin
            a_reg   <= req_a[win*WIDTH +: WIDTH];
            b_reg   <= req_b[win*WIDTH +: WIDTH];
            sel_reg <= req_sel[win*3 +: 3];
            id_reg  <= win;
         end
         if (state == EXEC) begin
            y_reg   <= alu_y;
            err_reg <= (sel_reg >= 3'b101);
         end
         if (state == RESP && rsp_ready)
            rr_ptr <= ptr_next;
      end
   end

   assign alu_a     = a_reg;
   assign alu_b     = b_reg;
   assign alu_sel   = sel_reg;
   assign rsp_valid = (state == RESP);
   assign rsp_id    = id_reg;
   assign rsp_y     = y_reg;
   assign rsp_err   = err_reg;

endmodule

`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
// ============================================================================
// tb_alu_share_arbiter : directed + randomized bench with a behavioural model.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_alu_share_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [15:0] req_a;
   logic [15:0] req_b;
   logic [11:0] req_sel;
   logic [3:0]  req_ready;
   logic [3:0]  alu_a;
   logic [3:0]  alu_b;
   logic [2:0]  alu_sel;
   logic [3:0]  alu_y;
   logic        rsp_valid;
   logic [1:0]  rsp_id;
   logic [3:0]  rsp_y;
   logic        rsp_err;
   logic        rsp_ready;

   logic [3:0]  op_a [NREQ];
   logic [3:0]  op_b [NREQ];
   logic [2:0]  op_s [NREQ];

   int compared   = 0;
   int mismatched = 0;
   int m_ptr      = 0;

   always #5 clk = ~clk;

   always_comb begin
      req_a   = '0;
      req_b   = '0;
      req_sel = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_a[i*4 +: 4]   = op_a[i];
         req_b[i*4 +: 4]   = op_b[i];
         req_sel[i*3 +: 3] = op_s[i];
      end
   end

   // Stand-in for the shared ALU instance.
   always_comb begin
      case (alu_sel)
         3'b000:  alu_y = alu_a + alu_b;
         3'b001:  alu_y = alu_a - alu_b;
         3'b010:  alu_y = alu_a & alu_b;
         3'b011:  alu_y = alu_a | alu_b;
         3'b100:  alu_y = ~alu_a;
         default: alu_y = 4'b0000;
      endcase
   end

   alu_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_sel   (req_sel),
      .req_ready (req_ready),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_sel   (alu_sel),
      .alu_y     (alu_y),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_y     (rsp_y),
      .rsp_err   (rsp_err),
      .rsp_ready (rsp_ready)
   );

   function automatic int ref_y(input int a, input int b, input int s);
      case (s)
         0:       return (a + b) % 16;
         1:       return (a - b + 16) % 16;
         2:       return a & b;
         3:       return a | b;
         4:       return 15 - a;
         default: return 0;
      endcase
   endfunction

   function automatic int pick(input logic [3:0] mask, input int ptr);
      for (int k = 0; k < NREQ; k++) begin
         if (mask[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      end
      return 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int r, input int a, input int b, input int s);
      op_a[r] = 4'(a);
      op_b[r] = 4'(b);
      op_s[r] = 3'(s);
   endtask

   // One full transaction; lit >= 0 overrides the model result with a literal.
   task automatic do_txn(input logic [3:0] mask, input int stall, input int lit);
      int         w;
      logic [3:0] ey;
      logic       ee;
      req_valid = mask;
      rsp_ready = 1'b0;
      #1;
      w  = pick(mask, m_ptr);
      ey = (lit >= 0) ? 4'(lit) : 4'(ref_y(op_a[w], op_b[w], op_s[w]));
      ee = (op_s[w] >= 3'd5);
      chk("accept_ready", req_ready, 32'(1 << w));
      step();
      req_valid = mask & ~(4'(1 << w));
      #1;
      chk("exec_ready", req_ready, 0);
      chk("exec_valid", rsp_valid, 0);
      chk("exec_alu_a", alu_a, op_a[w]);
      chk("exec_alu_b", alu_b, op_b[w]);
      chk("exec_alu_sel", alu_sel, op_s[w]);
      step();
      for (int c = 0; c <= stall; c++) begin
         if (c == stall) begin
            rsp_ready = 1'b1;
            #1;
         end
         chk("resp_valid", rsp_valid, 1);
         chk("resp_id", rsp_id, w);
         chk("resp_y", rsp_y, ey);
         chk("resp_err", rsp_err, ee);
         chk("resp_no_ready", req_ready, 0);
         step();
      end
      rsp_ready = 1'b0;
      m_ptr     = (w + 1) % NREQ;
      chk("back_idle_valid", rsp_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int         exp_order [5];
      int         q [$];
      int         g;
      int         rcv;
      int         last;
      int         id;
      logic [3:0] m;

      exp_order = '{0, 1, 2, 3, 0};
      for (int i = 0; i < NREQ; i++) set_op(i, 0, 0, 0);
      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b1;
      step();
      step();
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_y", rsp_y, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      chk("rst_alu_sel", alu_sel, 0);
      rst_n = 1'b1;
      step();
      chk("idle_no_req_ready", req_ready, 0);
      chk("idle_rsp_ready_ignored", rsp_valid, 0);
      rsp_ready = 1'b0;

      // Directed ops with hand-derived results.
      set_op(0, 4'b0101, 4'b0011, 3'b000);
      do_txn(4'b0001, 0, 4'b1000);
      set_op(1, 4'b0011, 4'b0101, 3'b001);
      do_txn(4'b0010, 0, 4'b1110);
      set_op(2, 4'b0101, 4'b0000, 3'b100);
      do_txn(4'b0100, 0, 4'b1010);
      set_op(3, 4'b0101, 4'b0011, 3'b110);
      do_txn(4'b1000, 0, 4'b0000);

      // Round robin with every requester continuously valid.
      for (int i = 0; i < NREQ; i++)
         set_op(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 4)));
      req_valid = 4'hF;
      rsp_ready = 1'b1;
      g    = 0;
      rcv  = 0;
      last = 0;
      for (int cyc = 0; cyc < 40 && rcv < 5; cyc++) begin
         #1;
         if (req_ready != 4'b0000) begin
            if (g < 5) begin
               chk("rr_grant", req_ready, 32'(1 << exp_order[g]));
               if (g > 0) chk("rr_spacing", cyc - last, 3);
               q.push_back(exp_order[g]);
            end
            last = cyc;
            g++;
         end
         if (rsp_valid) begin
            if (q.size() > 0) begin
               id = q.pop_front();
               chk("rr_rsp_id", rsp_id, id);
               chk("rr_rsp_y", rsp_y, ref_y(op_a[id], op_b[id], op_s[id]));
            end
            rcv++;
         end
         step();
      end
      req_valid = '0;
      rsp_ready = 1'b0;
      chk("rr_grant_count", g, 5);
      chk("rr_rsp_count", rcv, 5);
      m_ptr = 1;

      set_op(1, 4'b0101, 4'b0011, 3'b011);
      do_txn(4'b0010, 0, 4'b0111);

      // Backpressure: 5 stalled cycles, then the pending requester is granted at once.
      set_op(2, 4'b1001, 4'b0100, 3'b010);
      set_op(1, 4'b1111, 4'b0001, 3'b000);
      do_txn(4'b0110, 5, -1);
      chk("bp_next_grant", req_ready, 32'(1 << pick(4'b0010, m_ptr)));
      do_txn(4'b0010, 0, -1);

      // Reset while in EXEC.
      set_op(2, 4'b0111, 4'b0001, 3'b000);
      req_valid = 4'b0100;
      #1;
      chk("pre_rst_grant", req_ready, 32'(1 << pick(4'b0100, m_ptr)));
      step();
      req_valid = 4'b1010;
      rst_n     = 1'b0;
      step();
      chk("abort_req_ready", req_ready, 0);
      chk("abort_rsp_valid", rsp_valid, 0);
      chk("abort_rsp_id", rsp_id, 0);
      chk("abort_rsp_y", rsp_y, 0);
      chk("abort_rsp_err", rsp_err, 0);
      chk("abort_alu_a", alu_a, 0);
      chk("abort_alu_b", alu_b, 0);
      chk("abort_alu_sel", alu_sel, 0);
      rst_n = 1'b1;
      #1;
      chk("post_rst_grant", req_ready, 4'b0010);
      m_ptr = 0;
      do_txn(4'b1010, 0, -1);

      // Randomized traffic against the model.
      for (int t = 0; t < 16; t++) begin
         for (int i = 0; i < NREQ; i++)
            set_op(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 7)));
         m = 4'($urandom_range(1, 15));
         do_txn(m, int'($urandom_range(0, 3)), -1);
      end
      req_valid = '0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

`default_nettype wire
